// File: rtl/cnt_job_dispatcher.sv
// Job dispatcher for the counter start/done handshake: buffers count jobs in a FIFO,
// launches them one at a time, counts completions and flags hung jobs with a watchdog.
module cnt_job_dispatcher #(
    parameter int unsigned CNT_WIDTH  = 7,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT_W  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 job_valid_i,
    input  logic [CNT_WIDTH-1:0] job_cnt_i,
    output logic                 job_ready_o,
    output logic                 start_o,
    output logic [CNT_WIDTH-1:0] cnt_val_o,
    input  logic                 idle_i,
    input  logic                 run_i,
    input  logic                 done_i,
    input  logic                 clr_i,
    output logic                 busy_o,
    output logic [7:0]           jobs_done_o,
    output logic                 timeout_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    // Watchdog value one short of expiry; the edge leaving it is the timeout edge.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [TIMEOUT_W-1:0] wd;

    logic [PW-1:0]        fill;
    logic [PW-1:0]        fill_nxt;
    logic [CNT_WIDTH-1:0] head;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 launch;
    logic                 discard;
    logic                 wait_done;
    logic                 expire;
    logic                 active_nxt;

    // run_i is monitoring-only; the wait state relies on done_i alone.
    logic unused_run;
    assign unused_run = run_i;

    // Per-cycle event decode shared by the FIFO and the FSM.
    always_comb begin
        fill       = wr_ptr - rd_ptr;
        empty      = (fill == '0);
        head       = mem[rd_ptr[AW-1:0]];
        push       = job_valid_i && job_ready_o;
        launch     = (state == S_IDLE) && !empty && idle_i && (head != '0);
        discard    = (state == S_IDLE) && !empty && (head == '0);
        pop        = launch || discard;
        wait_done  = (state == S_WAIT) && done_i;
        expire     = (state == S_WAIT) && !done_i && (wd == WD_LAST);
        fill_nxt   = fill + PW'(push) - PW'(pop);
        active_nxt = launch || (state == S_LAUNCH) ||
                     ((state == S_WAIT) && !done_i && !expire);
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= job_cnt_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wd          <= '0;
            start_o     <= 1'b0;
            cnt_val_o   <= '0;
            jobs_done_o <= '0;
            timeout_o   <= 1'b0;
            busy_o      <= 1'b0;
            job_ready_o <= 1'b1;
        end else begin
            start_o     <= launch;
            busy_o      <= active_nxt || (fill_nxt != '0);
            job_ready_o <= (fill_nxt != PW'(FIFO_DEPTH));

            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (launch) begin
                cnt_val_o <= head;
            end

            case (state)
                S_IDLE: begin
                    if (launch) begin
                        state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wd    <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    wd <= wd + TIMEOUT_W'(1);
                    if (wait_done || expire) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Clear has priority over a same-edge completion or timeout.
            if (clr_i) begin
                jobs_done_o <= '0;
            end else if (wait_done) begin
                jobs_done_o <= jobs_done_o + 8'd1;
            end

            if (clr_i) begin
                timeout_o <= 1'b0;
            end else if (expire) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule
